// File: rtl/bomb_placer_pkg.sv
// bomb_placer_pkg: bomb FSM states, sprite geometry, video defaults and grid-snap helper.
package bomb_placer_pkg;
   typedef enum logic [1:0] {IDLE, ARMED, EXPLODE} state_t;
   localparam int BOMB_SIZE    = 32;
   localparam int GRID_SHIFT   = 5;
   localparam int VID_SCREEN_W = 640;
   localparam int VID_SCREEN_H = 480;
   // Centre on the grid cell under the player, then keep the whole square on screen.
   function automatic logic [10:0] snap(input logic [10:0] p, input int lim);
      logic [11:0] s;
      s = ({1'b0, p} + 12'd16) & ~12'((1 << GRID_SHIFT) - 1);
      return (s > 12'(lim)) ? 11'(lim) : s[10:0];
   endfunction
endpackage

// File: rtl/bomb_placer_if.sv
// bomb_placer_if: frame/keypad/pixel inputs and bomb sprite outputs of bomb_placer.
interface bomb_placer_if;
   logic        startOfFrame, placeBomb;
   logic [10:0] playerTopLeftX, playerTopLeftY, pixelX, pixelY;
   logic [10:0] offsetX, offsetY, bombTopLeftX, bombTopLeftY;
   logic        InsideRectangle, bombActive, explodePulse, blastActive;
   modport master (output startOfFrame, placeBomb, playerTopLeftX, playerTopLeftY, pixelX, pixelY,
                   input offsetX, offsetY, bombTopLeftX, bombTopLeftY,
                   input InsideRectangle, bombActive, explodePulse, blastActive);
   modport slave  (input startOfFrame, placeBomb, playerTopLeftX, playerTopLeftY, pixelX, pixelY,
                   output offsetX, offsetY, bombTopLeftX, bombTopLeftY,
                   output InsideRectangle, bombActive, explodePulse, blastActive);
endinterface

// File: rtl/bomb_placer_square_hit_reg.sv
// square_hit_reg: registered hit test and pixel offset for a SIZE x SIZE sprite square.
module square_hit_reg
   import bomb_placer_pkg::*;
#(
   parameter int SIZE = BOMB_SIZE
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        i_en,
   input  logic [10:0] i_pixel_x,
   input  logic [10:0] i_pixel_y,
   input  logic [10:0] i_top_x,
   input  logic [10:0] i_top_y,
   output logic        o_inside,
   output logic [10:0] o_offset_x,
   output logic [10:0] o_offset_y
);
   logic [10:0] w_dx, w_dy;
   logic        w_hit;
   logic        r_inside;
   logic [10:0] r_off_x, r_off_y;
   assign w_dx  = i_pixel_x - i_top_x;
   assign w_dy  = i_pixel_y - i_top_y;
   assign w_hit = i_en && (i_pixel_x >= i_top_x) && (w_dx < 11'(SIZE))
                       && (i_pixel_y >= i_top_y) && (w_dy < 11'(SIZE));
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_inside <= 1'b0;
         r_off_x  <= '0;
         r_off_y  <= '0;
      end else begin
         r_inside <= w_hit;
         r_off_x  <= w_hit ? w_dx : '0;
         r_off_y  <= w_hit ? w_dy : '0;
      end
   end
   assign o_inside   = r_inside;
   assign o_offset_x = r_off_x;
   assign o_offset_y = r_off_y;
endmodule

// File: rtl/bomb_placer.sv
// bomb_placer: drops one grid-snapped bomb, runs its fuse and blast in frames, and draws it.
module bomb_placer
   import bomb_placer_pkg::*;
#(
   parameter int FUSE_FRAMES  = 120,
   parameter int BLAST_FRAMES = 30,
   parameter int SCREEN_W     = VID_SCREEN_W,
   parameter int SCREEN_H     = VID_SCREEN_H
) (
   input  logic         clk,
   input  logic         resetN,
   bomb_placer_if.slave bus
);
   state_t      r_state;
   logic [9:0]  r_fuse_cnt, r_blast_cnt;
   logic [10:0] r_bomb_x, r_bomb_y;
   logic        r_explode;
   logic        w_armed;
   assign w_armed = (r_state == ARMED);
   // Placement wins over a coincident frame pulse, so the fuse always runs a full count.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state     <= IDLE;
         r_fuse_cnt  <= '0;
         r_blast_cnt <= '0;
         r_bomb_x    <= '0;
         r_bomb_y    <= '0;
         r_explode   <= 1'b0;
      end else begin
         r_explode <= 1'b0;
         case (r_state)
            IDLE: if (bus.placeBomb) begin
               r_bomb_x   <= snap(bus.playerTopLeftX, SCREEN_W - BOMB_SIZE);
               r_bomb_y   <= snap(bus.playerTopLeftY, SCREEN_H - BOMB_SIZE);
               r_fuse_cnt <= 10'(FUSE_FRAMES - 1);
               r_state    <= ARMED;
            end
            ARMED: if (bus.startOfFrame) begin
               if (r_fuse_cnt != '0) r_fuse_cnt <= r_fuse_cnt - 10'd1;
               else begin
                  r_explode   <= 1'b1;
                  r_blast_cnt <= 10'(BLAST_FRAMES - 1);
                  r_state     <= EXPLODE;
               end
            end
            EXPLODE: if (bus.startOfFrame) begin
               if (r_blast_cnt != '0) r_blast_cnt <= r_blast_cnt - 10'd1;
               else r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   square_hit_reg #(.SIZE(BOMB_SIZE)) u_hit (
      .clk        (clk),
      .resetN     (resetN),
      .i_en       (w_armed),
      .i_pixel_x  (bus.pixelX),
      .i_pixel_y  (bus.pixelY),
      .i_top_x    (r_bomb_x),
      .i_top_y    (r_bomb_y),
      .o_inside   (bus.InsideRectangle),
      .o_offset_x (bus.offsetX),
      .o_offset_y (bus.offsetY)
   );
   assign bus.bombActive   = w_armed;
   assign bus.blastActive  = (r_state == EXPLODE);
   assign bus.explodePulse = r_explode;
   assign bus.bombTopLeftX = r_bomb_x;
   assign bus.bombTopLeftY = r_bomb_y;
endmodule

// File: tb/tb_bomb_placer.sv
// tb_bomb_placer: directed snap table plus fuse, hit, blast, re-arm and reset sequences.
module tb_bomb_placer;
   logic clk = 1'b0;
   logic resetN = 1'b0;
   int   n_vec = 0, n_bad = 0, pulses = 0;
   bomb_placer_if bus();
   bomb_placer #(.FUSE_FRAMES(3), .BLAST_FRAMES(2)) dut (.clk(clk), .resetN(resetN), .bus(bus));
   always #5 clk = ~clk;
   always @(negedge clk) if (resetN && bus.explodePulse) pulses++;
   typedef struct {logic [10:0] px, py, bx, by;} vec_t;
   vec_t tbl[7];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk); #1;
   endtask
   task automatic frame();
      bus.startOfFrame = 1'b1; tick();
      bus.startOfFrame = 1'b0; repeat (3) tick();
   endtask
   task automatic place(input logic [10:0] x, input logic [10:0] y);
      bus.playerTopLeftX = x; bus.playerTopLeftY = y;
      bus.placeBomb = 1'b1; tick();
      bus.placeBomb = 1'b0; tick();
   endtask
   task automatic do_reset();
      resetN = 1'b0; tick(); tick();
      resetN = 1'b1; tick();
   endtask
   task automatic pix(input logic [10:0] x, input logic [10:0] y, input logic ins,
                      input logic [10:0] ox, input logic [10:0] oy);
      bus.pixelX = x; bus.pixelY = y; tick();
      chk("inside", 32'(bus.InsideRectangle), 32'(ins));
      chk("offsetX", 32'(bus.offsetX), 32'(ox));
      chk("offsetY", 32'(bus.offsetY), 32'(oy));
   endtask
   initial begin
      tbl[0] = '{11'd100, 11'd50,  11'd96,  11'd64};
      tbl[1] = '{11'd630, 11'd470, 11'd608, 11'd448};
      tbl[2] = '{11'd0,   11'd0,   11'd0,   11'd0};
      tbl[3] = '{11'd15,  11'd15,  11'd0,   11'd0};
      tbl[4] = '{11'd16,  11'd16,  11'd32,  11'd32};
      tbl[5] = '{11'd300, 11'd300, 11'd288, 11'd288};
      tbl[6] = '{11'd2000, 11'd1000, 11'd608, 11'd448};
      bus.startOfFrame = 0; bus.placeBomb = 0;
      bus.playerTopLeftX = 0; bus.playerTopLeftY = 0; bus.pixelX = 0; bus.pixelY = 0;
      #2;
      chk("rst bombActive", 32'(bus.bombActive), 0);
      chk("rst blastActive", 32'(bus.blastActive), 0);
      chk("rst explodePulse", 32'(bus.explodePulse), 0);
      chk("rst inside", 32'(bus.InsideRectangle), 0);
      chk("rst bombX", 32'(bus.bombTopLeftX), 0);
      chk("rst offsetX", 32'(bus.offsetX), 0);
      do_reset();
      foreach (tbl[i]) begin
         do_reset();
         place(tbl[i].px, tbl[i].py);
         chk($sformatf("snap%0d X", i), 32'(bus.bombTopLeftX), 32'(tbl[i].bx));
         chk($sformatf("snap%0d Y", i), 32'(bus.bombTopLeftY), 32'(tbl[i].by));
         chk($sformatf("snap%0d active", i), 32'(bus.bombActive), 1);
      end
      do_reset();
      pulses = 0;
      place(11'd100, 11'd50);
      pix(11'd127, 11'd95, 1'b1, 11'd31, 11'd31);
      pix(11'd128, 11'd95, 1'b0, 11'd0, 11'd0);
      pix(11'd96, 11'd64, 1'b1, 11'd0, 11'd0);
      pix(11'd95, 11'd64, 1'b0, 11'd0, 11'd0);
      pix(11'd100, 11'd96, 1'b0, 11'd0, 11'd0);
      frame();
      place(11'd300, 11'd300);
      chk("rearm X kept", 32'(bus.bombTopLeftX), 96);
      chk("rearm Y kept", 32'(bus.bombTopLeftY), 64);
      frame();
      chk("no pulse after 2", 32'(pulses), 0);
      chk("armed after 2", 32'(bus.bombActive), 1);
      frame();
      chk("pulse on 3rd", 32'(pulses), 1);
      chk("blast after 3", 32'(bus.blastActive), 1);
      chk("not armed after 3", 32'(bus.bombActive), 0);
      pix(11'd100, 11'd70, 1'b0, 11'd0, 11'd0);
      frame();
      chk("blast frame 2", 32'(bus.blastActive), 1);
      frame();
      chk("blast done", 32'(bus.blastActive), 0);
      chk("single pulse", 32'(pulses), 1);
      place(11'd200, 11'd100);
      chk("reaccept active", 32'(bus.bombActive), 1);
      chk("reaccept X", 32'(bus.bombTopLeftX), 192);
      chk("reaccept Y", 32'(bus.bombTopLeftY), 96);
      do_reset();
      pulses = 0;
      bus.playerTopLeftX = 11'd100; bus.playerTopLeftY = 11'd50;
      bus.placeBomb = 1'b1; bus.startOfFrame = 1'b1; tick();
      bus.placeBomb = 1'b0; bus.startOfFrame = 1'b0; tick();
      chk("coincident armed", 32'(bus.bombActive), 1);
      frame(); frame();
      chk("coincident no early pulse", 32'(pulses), 0);
      frame();
      chk("coincident pulse on 3rd", 32'(pulses), 1);
      do_reset();
      pulses = 0;
      place(11'd100, 11'd50);
      frame();
      bus.pixelX = 11'd100; bus.pixelY = 11'd70; tick();
      chk("pre-reset inside", 32'(bus.InsideRectangle), 1);
      #2 resetN = 1'b0; #1;
      chk("async bombActive", 32'(bus.bombActive), 0);
      chk("async inside", 32'(bus.InsideRectangle), 0);
      chk("async offsetY", 32'(bus.offsetY), 0);
      chk("async bombX", 32'(bus.bombTopLeftX), 0);
      chk("async bombY", 32'(bus.bombTopLeftY), 0);
      tick(); resetN = 1'b1; tick();
      repeat (5) frame();
      chk("aborted no pulse", 32'(pulses), 0);
      chk("aborted idle", 32'(bus.bombActive), 0);
      chk("aborted no blast", 32'(bus.blastActive), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/bomb_placer.md
BOMB_PLACER -- requirements
Module: bomb_placer

Interface
REQ-001 Parameter FUSE_FRAMES, default 120, number of frames from placement to explosion (1..1023).
REQ-002 Parameter BLAST_FRAMES, default 30, number of frames the EXPLODE state is held (1..1023).
REQ-003 Parameter SCREEN_W, default 640, horizontal pixel count; SCREEN_H, default 480, vertical pixel count.
REQ-004 clk  input  1  system pixel clock.
REQ-005 resetN  input  1  asynchronous, active-low reset.
REQ-006 startOfFrame  input  1  one-cycle pulse per video frame.
REQ-007 placeBomb  input  1  one-cycle request from the keypad to drop a bomb.
REQ-008 playerTopLeftX / playerTopLeftY  input  11 each  current player sprite top-left position.
REQ-009 pixelX / pixelY  input  11 each  current scan pixel.
REQ-010 offsetX / offsetY  output  11 each  pixel offset from the bomb top-left; feeds the bomb bitmap.
REQ-011 InsideRectangle  output  1  pixel lies inside the active 32x32 bomb square.
REQ-012 bombActive  output  1  high in the ARMED state.
REQ-013 explodePulse  output  1  one-cycle pulse when the fuse expires.
REQ-014 blastActive  output  1  high in the EXPLODE state.
REQ-015 bombTopLeftX / bombTopLeftY  output  11 each  latched bomb position.

Function
REQ-016 FSM states SHALL be IDLE, ARMED and EXPLODE.
REQ-017 IDLE with placeBomb=1: in one cycle, latch the snapped position (REQ-020), load fuseCnt=FUSE_FRAMES-1, and go to ARMED.
REQ-018 placeBomb in ARMED or EXPLODE SHALL be ignored (one bomb at a time).
REQ-019 placeBomb and startOfFrame in the same IDLE cycle: the placement takes effect and that frame is not counted.
REQ-020 Snap: X = (playerTopLeftX+16) with bits [4:0] cleared, clamped to SCREEN_W-32; Y is the same, clamped to SCREEN_H-32.
REQ-021 ARMED: on startOfFrame, decrement fuseCnt if it is nonzero; on startOfFrame with fuseCnt=0, assert explodePulse for one cycle, load blastCnt=BLAST_FRAMES-1, and go to EXPLODE.
REQ-022 Fuse duration: exactly FUSE_FRAMES startOfFrame pulses after the placement cycle, counting the expiring pulse.
REQ-023 EXPLODE: on startOfFrame, decrement blastCnt; on startOfFrame with blastCnt=0, go to IDLE.
REQ-024 The latched bomb position SHALL NOT follow player motion after placement.
REQ-025 Hit test SHALL require state==ARMED, bombTopLeftX <= pixelX < bombTopLeftX+32, and bombTopLeftY <= pixelY < bombTopLeftY+32.
REQ-026 InsideRectangle, offsetX and offsetY SHALL be registered: one clk of latency from pixelX/pixelY.
REQ-027 Offsets SHALL be pixel minus bomb top-left in unsigned 11-bit arithmetic when inside, and 0 when outside.
REQ-028 bombActive and blastActive SHALL be combinational decodes of the registered state.
REQ-029 Counters SHALL be 10 bits wide.

Reset
REQ-030 On resetN=0, asynchronously: state=IDLE, fuseCnt=blastCnt=0, bombTopLeftX/Y=0, offsetX/Y=0, and InsideRectangle=explodePulse=bombActive=blastActive=0.
REQ-031 A reset asserted mid-fuse or mid-blast SHALL abort the operation with no explodePulse; after release the block waits in IDLE for a new placeBomb.

Structure
REQ-032 The state enum, BOMB_SIZE=32 and GRID_SHIFT=5 SHALL live in the shared bomb package, with SCREEN_W and SCREEN_H taken from the shared video package defaults.
REQ-033 The pixel hit test and offset register SHALL be a sub-module named square_hit_reg, reusable by other sprites; the FSM and counters stay in bomb_placer.

Verification
REQ-034 FUSE_FRAMES=3, player (100,50), one placeBomb -> bombTopLeft=(96,64), bombActive=1; explodePulse on the 3rd startOfFrame; exactly one pulse.
REQ-035 Armed bomb at (96,64), pixel (127,95) -> next cycle InsideRectangle=1, offset=(31,31); pixel (128,95) -> InsideRectangle=0, offset=(0,0).
REQ-036 Player (630,470) placeBomb -> bombTopLeft=(608,448).
REQ-037 Second placeBomb while ARMED, with the player moved to (300,300) -> position and fuseCnt unchanged; placeBomb coincident with startOfFrame in IDLE -> full FUSE_FRAMES count.
REQ-038 BLAST_FRAMES=2 -> blastActive high for 2 frames after explodePulse, then IDLE; a new placeBomb is accepted.
REQ-039 resetN pulsed low mid-fuse -> all outputs 0 immediately; no explodePulse afterwards until a new placement.
